ref_bank_pingpong: RTL
======================

// Module: ref_bank_pingpong
// PURPOSE
//  Parametrised multi-bank reference-pixel buffer for the integer ME search window.
//  Row writer fills one bank while the PE array reads a previously filled bank.
//  Banks rotate in a ring: EMPTY -> FILL -> FULL -> READ -> EMPTY.
//  Sits between the external reference fetch and the SAD array.
// PARAMETERS
//  PIXEL_W     8   bits per pixel
//  PIX_PER_ROW 8   pixels per memory word (row slice)
//  DEPTH       96  words per bank
//  ADDR_W      7   word address width; DEPTH <= 2**ADDR_W
//  NUM_BANKS   2   bank count, >= 2
// PORTS
//  clk           in   1                   rising-edge clock
//  rst           in   1                   asynchronous reset, active-high
//  wr_valid      in   1                   write request
//  wr_ready      out  1                   current write bank accepts data
//  wr_addr       in   ADDR_W              write word address
//  wr_data       in   PIXEL_W*PIX_PER_ROW write word
//  wr_last       in   1                   last word of bank fill; qualified by wr_valid & wr_ready
//  rd_en         in   1                   read request, active-high
//  rd_addr       in   ADDR_W              read word address
//  rd_data       out  PIXEL_W*PIX_PER_ROW read word, registered
//  rd_valid      out  1                   rd_data valid this cycle
//  rd_release    in   1                   reader finished with current bank
//  rd_bank_ready out  1                   current read bank is FULL or READ
//  wr_bank_idx   out  $clog2(NUM_BANKS)   bank index the writer targets
//  rd_bank_idx   out  $clog2(NUM_BANKS)   bank index the reader targets
//  err_addr      out  1                   sticky: address >= DEPTH seen
// BEHAVIOUR
//  Reset (async, immediate): all bank states EMPTY; wp = rp = 0; rd_valid = 0; rd_data = 0; err_addr = 0.
//    Memory contents are not cleared. Reset mid-fill or mid-read discards all pending data.
//  wr_ready = state[wp] is EMPTY or FILL. This is combinational from registered state.
//  Write accept (wr_valid & wr_ready):
//    - mem[wp][wr_addr] <= wr_data.
//    - state[wp] becomes FILL.
//    - With wr_last: state[wp] becomes FULL and wp <= (wp == NUM_BANKS-1) ? 0 : wp + 1.
//  wr_valid while !wr_ready: stall. Writer holds data; nothing is written and nothing is dropped.
//  rd_bank_ready = state[rp] is FULL or READ.
//  Read accept (rd_en & rd_bank_ready):
//    - rd_data <= mem[rp][rd_addr] and rd_valid <= 1. Latency is 1 cycle.
//    - FULL becomes READ.
//  rd_en while !rd_bank_ready: ignored. rd_valid <= 0; rd_data holds its last value.
//  Release (rd_release & rd_bank_ready): state[rp] becomes EMPTY; rp advances, wrapping as wp does.
//    Released bank is writable (wr_ready) the cycle after release.
//  rd_release while !rd_bank_ready: ignored.
//  Simultaneous rd_en and rd_release: read uses the old rp; data returns next cycle; rp then advances.
//  Write and read in the same cycle target different banks by construction (wp != rp when both are active).
//  wp == rp with state FULL means all banks are full: wr_ready = 0.
//  Out-of-range write address (>= DEPTH): word discarded, handshake still completes (wr_last honoured), err_addr <= 1.
//  Out-of-range read address (>= DEPTH): rd_data <= 0, rd_valid <= 1, err_addr <= 1.
//  err_addr is cleared only by rst.
// STRUCTURE
//  Package me_ref_pkg:
//    - bank_state_t enum {EMPTY, FILL, FULL, READ}
//    - PIXEL_W default, and a word-width function PIXEL_W*PIX_PER_ROW
//  Sub-module ref_bank_mem: one bank, 1 write / 1 read, synchronous read, no reset on storage.
//    Instantiated NUM_BANKS times via generate.
//  Top level holds the state array, wp/rp pointers, the output mux and the rd_data/rd_valid registers.
// TESTING
//  1 Reset: assert rst mid-cycle -> wr_ready=1, rd_bank_ready=0, rd_valid=0, rd_data=0, idx=0 without waiting for clk.
//  2 Fill and read: fill bank0 addr 0..95 with {8{addr[7:0]}}, wr_last at 95 -> wr_bank_idx=1, rd_bank_ready=1.
//    Then read 0,1,3,4,5 -> rd_data {8{8'h00}},{8{8'h01}},{8{8'h03}},{8{8'h04}},{8{8'h05}}, each 1 cycle later.
//  3 Ping-pong: write bank1 with {8{8'hA5}} while reading all of bank0 -> bank0 data unchanged.
//    Then release -> rd_bank_idx=1; read addr 7 -> {8{8'hA5}}.
//  4 Backpressure: fill both banks, no release -> wr_ready=0; hold wr_valid 5 cycles -> no write occurs.
//    rd_release -> wr_ready=1 next cycle; the held word is written to bank0.
//  5 Same-cycle rd_en+rd_release at addr 2 of bank0 -> rd_data {8{8'h02}} next cycle; rd_bank_idx=1; bank0 EMPTY.
//  6 Errors: write addr 100 -> err_addr=1, memory unchanged; read addr 120 -> rd_data=0, rd_valid=1.
//    rst mid-fill -> wr_bank_idx=0, rd_bank_ready=0.

Source files
------------

// File: rtl/me_ref_pkg.sv
// Shared types and width helpers for the ME reference-pixel bank buffer.
package me_ref_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2,
        READ  = 2'd3
    } bank_state_t;

    localparam int PIXEL_W_DEF     = 8;
    localparam int PIX_PER_ROW_DEF = 8;

    function automatic int word_w(input int pixel_w, input int pix_per_row);
        return pixel_w * pix_per_row;
    endfunction

endpackage

// File: rtl/ref_bank_mem.sv
// One reference bank: 1 write / 1 read port, registered read data, storage not reset.
// Read data appears the cycle after re and holds while re is low.
module ref_bank_mem
    import me_ref_pkg::*;
#(
    parameter int WORD_W = word_w(PIXEL_W_DEF, PIX_PER_ROW_DEF),
    parameter int DEPTH  = 96,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ref_bank_pingpong.sv
// Multi-bank ring buffer of reference rows: writer fills bank wp while the SAD array reads bank rp.
// Read latency 1 cycle; writer stalls (wr_ready low) when every bank is full, reads ignored on an unfilled bank.
module ref_bank_pingpong
    import me_ref_pkg::*;
#(
    parameter int PIXEL_W     = PIXEL_W_DEF,
    parameter int PIX_PER_ROW = PIX_PER_ROW_DEF,
    parameter int DEPTH       = 96,
    parameter int ADDR_W      = 7,
    parameter int NUM_BANKS   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [PIXEL_W*PIX_PER_ROW-1:0] wr_data,
    input  logic                           wr_last,
    input  logic                           rd_en,
    input  logic [ADDR_W-1:0]              rd_addr,
    output logic [PIXEL_W*PIX_PER_ROW-1:0] rd_data,
    output logic                           rd_valid,
    input  logic                           rd_release,
    output logic                           rd_bank_ready,
    output logic [$clog2(NUM_BANKS)-1:0]   wr_bank_idx,
    output logic [$clog2(NUM_BANKS)-1:0]   rd_bank_idx,
    output logic                           err_addr
);

    localparam int                WORD_W   = word_w(PIXEL_W, PIX_PER_ROW);
    localparam int                IDX_W    = $clog2(NUM_BANKS);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_BANKS - 1);

    bank_state_t       state     [NUM_BANKS];
    bank_state_t       state_nxt [NUM_BANKS];
    logic [IDX_W-1:0]  wp, rp, wp_nxt, rp_nxt;
    logic [IDX_W-1:0]  rd_sel;
    logic              rd_oor;
    logic              wr_acc, rd_acc, rel_acc;
    logic              wr_in_range, rd_in_range;
    logic [WORD_W-1:0] bank_rdata [NUM_BANKS];

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    assign wr_ready      = (state[wp] == EMPTY) || (state[wp] == FILL);
    assign rd_bank_ready = (state[rp] == FULL)  || (state[rp] == READ);

    assign wr_acc  = wr_valid && wr_ready;
    assign rd_acc  = rd_en && rd_bank_ready;
    assign rel_acc = rd_release && rd_bank_ready;

    assign wr_in_range = {1'b0, wr_addr} < DEPTH_L;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_L;

    assign wr_bank_idx = wp;
    assign rd_bank_idx = rp;

    // Writer and reader never touch the same bank in one cycle, so their updates cannot collide.
    always_comb begin
        state_nxt = state;
        wp_nxt    = wp;
        rp_nxt    = rp;
        if (wr_acc) begin
            state_nxt[wp] = wr_last ? FULL : FILL;
            if (wr_last) begin
                wp_nxt = next_idx(wp);
            end
        end
        if (rd_acc && (state[rp] == FULL)) begin
            state_nxt[rp] = READ;
        end
        if (rel_acc) begin
            state_nxt[rp] = EMPTY;
            rp_nxt        = next_idx(rp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state[b] <= EMPTY;
            end
            wp       <= '0;
            rp       <= '0;
            rd_sel   <= '0;
            rd_oor   <= 1'b1;
            rd_valid <= 1'b0;
            err_addr <= 1'b0;
        end else begin
            state    <= state_nxt;
            wp       <= wp_nxt;
            rp       <= rp_nxt;
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_sel <= rp;
                rd_oor <= !rd_in_range;
            end
            if ((wr_acc && !wr_in_range) || (rd_acc && !rd_in_range)) begin
                err_addr <= 1'b1;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ref_bank_mem #(
            .WORD_W (WORD_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_mem (
            .clk   (clk),
            .we    (wr_acc && wr_in_range && (wp == IDX_W'(b))),
            .waddr (wr_addr),
            .wdata (wr_data),
            .re    (rd_acc && rd_in_range && (rp == IDX_W'(b))),
            .raddr (rd_addr),
            .rdata (bank_rdata[b])
        );
    end

    // rd_oor doubles as the post-reset "no data yet" flag; bank registers hold between reads.
    assign rd_data = rd_oor ? '0 : bank_rdata[rd_sel];

endmodule
